// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD engine.
// state_t is the frame state broadcast from axi_tdd_ng_counter to every
// axi_tdd_ng_channel instance. The channels compare against IDLE, ARMED and RUNNING,
// so the encoding below must stay fixed.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    WAITING = 2'b10,
    RUNNING = 2'b11
  } state_t;

endpackage

// File: rtl/axi_tdd_ng_counter.sv
// TDD engine timing master: frame state machine, frame counter and burst counter.
//
// Ports:
//   clk                core clock
//   rst                asynchronous active-high reset
//   tdd_enable         engine enable level from the register map
//   tdd_sync           single-cycle sync pulse (clk domain, external or soft)
//   tdd_startup_delay  cycles from sync to first frame
//   tdd_frame_length   frame length in cycles (0 behaves as 1)
//   tdd_burst_count    frames per burst, 0 = infinite
//   tdd_counter        current counter value
//   tdd_cstate         current state
//   tdd_endof_frame    high during the last cycle of each RUNNING frame
//   tdd_endof_burst    one-cycle pulse after the final frame of a finite burst
//   tdd_running        high while in WAITING or RUNNING
//
// Build option:
//   AXI_TDD_NG_SYNC_RESET_EN  when defined, a sync pulse in WAITING or RUNNING restarts
//                             the sequence exactly as from ARMED. Otherwise sync is
//                             only honoured in ARMED.
//
// All outputs are registered. Register inputs are sampled live and are expected to be
// stable while tdd_enable is high.
module axi_tdd_ng_counter
  import axi_tdd_ng_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH    = 32,
  parameter int unsigned BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output state_t                       tdd_cstate,
  output logic                         tdd_endof_frame,
  output logic                         tdd_endof_burst,
  output logic                         tdd_running
);

  localparam logic [REGISTER_WIDTH-1:0]    RegZero   = '0;
  localparam logic [REGISTER_WIDTH-1:0]    RegOne    = REGISTER_WIDTH'(1);
  localparam logic [BURST_COUNT_WIDTH-1:0] BurstZero = '0;
  localparam logic [BURST_COUNT_WIDTH-1:0] BurstOne  = BURST_COUNT_WIDTH'(1);

  state_t                       cstate_q, cstate_d;
  logic [REGISTER_WIDTH-1:0]    counter_q, counter_d;
  logic [BURST_COUNT_WIDTH-1:0] burst_q, burst_d;
  logic                         eof_q, eof_d;
  logic                         eob_q, eob_d;
  logic                         running_q, running_d;

  logic [REGISTER_WIDTH-1:0]    frame_last;
  logic                         frame_end;
  logic                         sync_accept;

  // Index of the last cycle of a frame; a zero length behaves as a one-cycle frame.
  assign frame_last = (tdd_frame_length == RegZero) ? RegZero : tdd_frame_length - RegOne;
  assign frame_end  = (counter_q == frame_last);

`ifdef AXI_TDD_NG_SYNC_RESET_EN
  assign sync_accept = tdd_sync && (cstate_q != IDLE);
`else
  assign sync_accept = tdd_sync && (cstate_q == ARMED);
`endif

  always_comb begin
    cstate_d  = cstate_q;
    counter_d = counter_q;
    burst_d   = burst_q;
    eob_d     = 1'b0;

    if (!tdd_enable) begin
      cstate_d  = IDLE;
      counter_d = RegZero;
      burst_d   = BurstZero;
    end else if (sync_accept) begin
      // A restart from WAITING/RUNNING truncates the current frame without a pulse,
      // since eof is recomputed below from the restarted counter.
      burst_d   = tdd_burst_count;
      counter_d = RegZero;
      cstate_d  = (tdd_startup_delay == RegZero) ? RUNNING : WAITING;
    end else begin
      unique case (cstate_q)
        IDLE: begin
          // A sync in the enabling cycle lands here and is dropped.
          cstate_d  = ARMED;
          counter_d = RegZero;
        end
        ARMED: begin
          counter_d = RegZero;
        end
        WAITING: begin
          if (counter_q == tdd_startup_delay - RegOne) begin
            cstate_d  = RUNNING;
            counter_d = RegZero;
          end else begin
            counter_d = counter_q + RegOne;
          end
        end
        RUNNING: begin
          if (frame_end) begin
            counter_d = RegZero;
            if (burst_q != BurstZero) begin
              if (burst_q == BurstOne) begin
                cstate_d = ARMED;
                burst_d  = BurstZero;
                eob_d    = 1'b1;
              end else begin
                burst_d = burst_q - BurstOne;
              end
            end
          end else begin
            counter_d = counter_q + RegOne;
          end
        end
      endcase
    end

    // Derived from next-state values so the registered flag lines up with tdd_counter.
    eof_d     = (cstate_d == RUNNING) && (counter_d == frame_last);
    running_d = (cstate_d == WAITING) || (cstate_d == RUNNING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cstate_q  <= IDLE;
      counter_q <= RegZero;
      burst_q   <= BurstZero;
      eof_q     <= 1'b0;
      eob_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      cstate_q  <= cstate_d;
      counter_q <= counter_d;
      burst_q   <= burst_d;
      eof_q     <= eof_d;
      eob_q     <= eob_d;
      running_q <= running_d;
    end
  end

  assign tdd_counter     = counter_q;
  assign tdd_cstate      = cstate_q;
  assign tdd_endof_frame = eof_q;
  assign tdd_endof_burst = eob_q;
  assign tdd_running     = running_q;

endmodule
